// File: rtl/systolic_pkg.sv
// Shared constants, FSM state encoding and product extension helper
// for the N x N weight-stationary systolic engine.
package systolic_pkg;

    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2
    } state_e;

    // Widen a product whose top bit sits at index msb; sign-fill above it
    // when the operands are two's-complement, zero-fill otherwise.
    // The caller keeps the low ACC_W bits.
    function automatic logic [63:0] ext_prod(input logic [63:0] p,
                                             input logic [5:0]  msb,
                                             input logic        sgn);
        logic [63:0] r;
        r = p;
        if (sgn && p[msb]) begin
            for (int k = 0; k < 64; k++) begin
                if (k > int'(msb)) r[k] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_array_nxn_if.sv
// Weight, activation and result handshakes of the systolic engine.
interface systolic_array_nxn_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic                  w_valid;
    logic                  w_ready;
    logic [N*DATA_W-1:0]   w_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [N*DATA_W-1:0]   a_data;
    logic [N*ACC_W-1:0]    c_data;
    logic                  y_valid;
    logic [N*ACC_W-1:0]    y_data;
    logic                  weights_loaded;

    modport master (
        output w_valid, w_data, a_valid, a_data, c_data,
        input  w_ready, a_ready, y_valid, y_data, weights_loaded
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, c_data,
        output w_ready, a_ready, y_valid, y_data, weights_loaded
    );
endinterface

// File: rtl/systolic_pe.sv
// One processing element: stationary shift-loaded weight, activation
// pass-through and a registered multiply-accumulate on the partial sum.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_w_shift,
    input  logic [DATA_W-1:0] i_w,
    output logic [DATA_W-1:0] o_w,
    input  logic [DATA_W-1:0] i_act,
    output logic [DATA_W-1:0] o_act,
    input  logic [ACC_W-1:0]  i_psum,
    output logic [ACC_W-1:0]  o_psum
);
    logic [DATA_W-1:0]   r_w;
    logic [DATA_W-1:0]   r_act;
    logic [ACC_W-1:0]    r_psum;
    logic [2*DATA_W-1:0] w_w_x;
    logic [2*DATA_W-1:0] w_a_x;
    logic [2*DATA_W-1:0] w_prod;
    logic [63:0]         w_ext;

    // Operands widened to the product width so the low half of an
    // unsigned multiply is also the correct two's-complement product.
    assign w_w_x  = {{DATA_W{(SIGNED != 0) && r_w[DATA_W-1]}}, r_w};
    assign w_a_x  = {{DATA_W{(SIGNED != 0) && i_act[DATA_W-1]}}, i_act};
    assign w_prod = w_w_x * w_a_x;
    assign w_ext  = ext_prod({{(64-2*DATA_W){1'b0}}, w_prod},
                             6'(2*DATA_W-1), SIGNED != 0);

    // Weight shifts in only on an accepted weight beat.
    always_ff @(posedge clk) begin
        if (reset)          r_w <= '0;
        else if (i_w_shift) r_w <= i_w;
    end

    // Activation hop and MAC, one cycle each; sums wrap at ACC_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act  <= '0;
            r_psum <= '0;
        end else begin
            r_act  <= i_act;
            r_psum <= i_psum + w_ext[ACC_W-1:0];
        end
    end

    assign o_w    = r_w;
    assign o_act  = r_act;
    assign o_psum = r_psum;
endmodule

// File: rtl/systolic_array_nxn.sv
// Weight-stationary N x N matrix-vector engine: y[j] = c[j] + sum_i W[i][j]*a[i].
// Whole vectors in and out; skew/deskew is internal, latency is exactly 2N.
module systolic_array_nxn
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_array_nxn_if.slave  bus
);
    localparam int STAGES = 2*N;
    localparam int IF_W   = $clog2(2*N+1);
    localparam int CNT_W  = $clog2(N+1);

    state_e                          r_state;
    logic [CNT_W-1:0]                r_wcnt;
    logic [IF_W-1:0]                 r_inflight;
    logic [STAGES:0]                 r_vld_pipe;
    logic [N-1:0][ACC_W-1:0]         r_y;

    logic                            w_w_acc;
    logic                            w_a_acc;
    logic [N-1:0][DATA_W-1:0]        w_w_in;
    logic [N-1:0][DATA_W-1:0]        w_a_in;
    logic [N-1:0][ACC_W-1:0]         w_c_in;
    logic [N-1:0][N:0][DATA_W-1:0]   w_act;
    logic [N-1:0][N:0][DATA_W-1:0]   w_wt;
    logic [N:0][N-1:0][ACC_W-1:0]    w_ps;
    logic [N-1:0][ACC_W-1:0]         w_dsk;

    assign w_w_in = bus.w_data;
    assign w_a_in = bus.a_data;
    assign w_c_in = bus.c_data;

    // Activations beat weights in a same-cycle conflict, and weights stay
    // frozen while any vector is still travelling through the array.
    assign bus.a_ready        = (r_state == ARMED);
    assign bus.w_ready        = (r_state != ARMED) || (r_inflight == '0 && !bus.a_valid);
    assign bus.weights_loaded = (r_state == ARMED);
    assign bus.y_valid        = r_vld_pipe[STAGES];
    assign bus.y_data         = r_y;

    assign w_w_acc = bus.w_valid && bus.w_ready;
    assign w_a_acc = bus.a_valid && bus.a_ready;

    // Load FSM: N accepted beats arm the array; any beat while armed restarts loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_wcnt  <= '0;
        end else if (w_w_acc) begin
            case (r_state)
                EMPTY, ARMED: begin
                    r_state <= LOADING;
                    r_wcnt  <= CNT_W'(1);
                end
                LOADING: begin
                    r_wcnt <= r_wcnt + CNT_W'(1);
                    if (r_wcnt == CNT_W'(N-1)) r_state <= ARMED;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Vectors in flight: accepted but not yet presented on y.
    always_ff @(posedge clk) begin
        if (reset) r_inflight <= '0;
        else begin
            case ({w_a_acc, bus.y_valid})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Valid bit rides alongside the data for the full 2N-cycle path.
    always_ff @(posedge clk) begin
        if (reset) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_a_acc};
    end

    // Output register updates only on a valid result and holds otherwise.
    always_ff @(posedge clk) begin
        if (reset)                      r_y <= '0;
        else if (r_vld_pipe[STAGES-1])  r_y <= w_dsk;
    end

    genvar i, j;
    generate
        for (i = 0; i < N; i++) begin : g_row
            logic [i:0][DATA_W-1:0] r_sk;
            // Row i activation delayed i cycles (plus the capture stage).
            always_ff @(posedge clk) begin
                if (reset) r_sk <= '0;
                else begin
                    r_sk[0] <= w_a_in[i];
                    for (int k = 1; k <= i; k++) r_sk[k] <= r_sk[k-1];
                end
            end
            assign w_act[i][0] = r_sk[i];
            assign w_wt[i][0]  = w_w_in[i];
        end

        for (j = 0; j < N; j++) begin : g_col
            logic [j:0][ACC_W-1:0] r_csk;
            // Column j initial sum delayed j cycles (plus the capture stage).
            always_ff @(posedge clk) begin
                if (reset) r_csk <= '0;
                else begin
                    r_csk[0] <= w_c_in[j];
                    for (int k = 1; k <= j; k++) r_csk[k] <= r_csk[k-1];
                end
            end
            assign w_ps[0][j] = r_csk[j];

            localparam int D = N-1-j;
            if (D == 0) begin : g_nodsk
                assign w_dsk[j] = w_ps[N][j];
            end else begin : g_dsk
                logic [D-1:0][ACC_W-1:0] r_dk;
                // Column j result delayed N-1-j cycles to realign the vector.
                always_ff @(posedge clk) begin
                    if (reset) r_dk <= '0;
                    else begin
                        r_dk[0] <= w_ps[N][j];
                        for (int k = 1; k < D; k++) r_dk[k] <= r_dk[k-1];
                    end
                end
                assign w_dsk[j] = r_dk[D-1];
            end
        end

        for (i = 0; i < N; i++) begin : g_pr
            for (j = 0; j < N; j++) begin : g_pc
                systolic_pe #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W),
                    .SIGNED (SIGNED)
                ) u_pe (
                    .clk       (clk),
                    .reset     (reset),
                    .i_w_shift (w_w_acc),
                    .i_w       (w_wt[i][j]),
                    .o_w       (w_wt[i][j+1]),
                    .i_act     (w_act[i][j]),
                    .o_act     (w_act[i][j+1]),
                    .i_psum    (w_ps[i][j]),
                    .o_psum    (w_ps[i+1][j])
                );
            end
        end
    endgenerate
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench: three configurations (signed/20b, unsigned/20b,
// unsigned/16b) share one stimulus stream.
module tb_systolic_array_nxn;
    logic clk;
    logic reset;
    logic w_valid, a_valid;
    logic [31:0] w_data, a_data;
    logic [3:0][19:0] c_data;

    int n_checks = 0;
    int n_err    = 0;

    systolic_array_nxn_if #(.N(4), .DATA_W(8), .ACC_W(20)) if_s ();
    systolic_array_nxn_if #(.N(4), .DATA_W(8), .ACC_W(20)) if_u ();
    systolic_array_nxn_if #(.N(4), .DATA_W(8), .ACC_W(16)) if_w ();

    assign if_s.w_valid = w_valid;  assign if_u.w_valid = w_valid;  assign if_w.w_valid = w_valid;
    assign if_s.w_data  = w_data;   assign if_u.w_data  = w_data;   assign if_w.w_data  = w_data;
    assign if_s.a_valid = a_valid;  assign if_u.a_valid = a_valid;  assign if_w.a_valid = a_valid;
    assign if_s.a_data  = a_data;   assign if_u.a_data  = a_data;   assign if_w.a_data  = a_data;
    assign if_s.c_data  = c_data;   assign if_u.c_data  = c_data;
    assign if_w.c_data  = {c_data[3][15:0], c_data[2][15:0], c_data[1][15:0], c_data[0][15:0]};

    systolic_array_nxn #(.N(4), .DATA_W(8), .ACC_W(20), .SIGNED(1)) dut_s (.clk(clk), .reset(reset), .bus(if_s));
    systolic_array_nxn #(.N(4), .DATA_W(8), .ACC_W(20), .SIGNED(0)) dut_u (.clk(clk), .reset(reset), .bus(if_u));
    systolic_array_nxn #(.N(4), .DATA_W(8), .ACC_W(16), .SIGNED(0)) dut_w (.clk(clk), .reset(reset), .bus(if_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]     beats;
        logic [31:0]      a;
        logic [3:0][19:0] c;
        logic [79:0]      exp_s;
        logic [79:0]      exp_u;
        logic [63:0]      exp_w;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d);
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = d;
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic load_beats(input logic [127:0] beats);
        for (int b = 0; b < 4; b++) beat(beats[32*b +: 32]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // One vector; returns results of all three configs and edges to y_valid.
    task automatic run_vec(input logic [31:0] a, input logic [3:0][19:0] c,
                           output logic [79:0] ys, output logic [79:0] yu,
                           output logic [63:0] yw, output int lat);
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = a;
        c_data  = c;
        @(negedge clk);
        a_valid = 1'b0;
        lat = -1;
        ys = '0; yu = '0; yw = '0;
        for (int n = 1; n <= 20; n++) begin
            if (if_s.y_valid) begin
                lat = n - 1;
                ys = if_s.y_data;
                yu = if_u.y_data;
                yw = if_w.y_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [79:0] ys, yu, yc;
        logic [63:0] yw;
        logic [79:0] ev;
        int lat, seen_y, lat_w, pulses;

        // identity: column j holds beat 3-j, which has a 1 in row j
        tbl[0] = '{128'h00000001_00000100_00010000_01000000, 32'h04030201, '0,
                   80'h00004_00003_00002_00001, 80'h00004_00003_00002_00001, 64'h0004_0003_0002_0001};
        tbl[1] = '{{4{32'hFFFFFFFF}}, 32'h7F7F7F7F, {20'd0, 20'd0, 20'd0, 20'd5},
                   80'hFFE04_FFE04_FFE04_FFE09, 80'h1FA04_1FA04_1FA04_1FA09, 64'hFA04_FA04_FA04_FA09};
        tbl[2] = '{{4{32'hFFFFFFFF}}, 32'hFFFFFFFF, '0,
                   80'h00004_00004_00004_00004, 80'h3F804_3F804_3F804_3F804, 64'hF804_F804_F804_F804};
        tbl[3] = '{128'h01010101_02020202_03030303_04040404, 32'h0502FF03, {20'd40, 20'd30, 20'd20, 20'd10},
                   80'h0004C_00039_00026_00013, 80'h0044C_00339_00226_00113, 64'h044C_0339_0226_0113};

        reset = 1'b1; w_valid = 1'b0; a_valid = 1'b0;
        w_data = '0; a_data = '0; c_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_y_valid", 80'(if_s.y_valid), 80'(0));
        chk("rst_y_data", if_s.y_data, 80'(0));
        chk("rst_loaded", 80'({if_s.weights_loaded, if_u.weights_loaded, if_w.weights_loaded}), 80'(0));
        chk("rst_a_ready", 80'(if_s.a_ready), 80'(0));
        chk("rst_w_ready", 80'(if_s.w_ready), 80'(1));

        for (int r = 0; r < 4; r++) begin
            load_beats(tbl[r].beats);
            chk($sformatf("tbl%0d_loaded", r),
                80'({if_s.weights_loaded, if_u.weights_loaded, if_w.weights_loaded}), 80'(7));
            run_vec(tbl[r].a, tbl[r].c, ys, yu, yw, lat);
            chk($sformatf("tbl%0d_latency", r), 80'(lat), 80'(8));
            chk($sformatf("tbl%0d_y_signed", r), ys, tbl[r].exp_s);
            chk($sformatf("tbl%0d_y_unsigned", r), yu, tbl[r].exp_u);
            chk($sformatf("tbl%0d_y_acc16", r), 80'(yw), 80'(tbl[r].exp_w));
        end

        // six back-to-back vectors through identity weights
        load_beats(tbl[0].beats);
        c_data = '0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (cyc < 6) begin
                a_valid = 1'b1;
                a_data  = {8'(10*cyc+4), 8'(10*cyc+3), 8'(10*cyc+2), 8'(10*cyc+1)};
            end else begin
                a_valid = 1'b0;
            end
            #1;
            chk($sformatf("stream_y_valid_c%0d", cyc), 80'(if_s.y_valid), 80'(cyc >= 9 && cyc <= 14));
            if (cyc >= 9 && cyc <= 14) begin
                ev = {20'(10*(cyc-9)+4), 20'(10*(cyc-9)+3), 20'(10*(cyc-9)+2), 20'(10*(cyc-9)+1)};
                chk($sformatf("stream_y_data_c%0d", cyc), if_s.y_data, ev);
            end
            chk($sformatf("stream_w_ready_c%0d", cyc), 80'(if_s.w_ready), 80'(cyc >= 15));
        end

        // weight beat and vector offered together while armed and idle
        @(negedge clk);
        w_valid = 1'b1; w_data = 32'h11111111;
        a_valid = 1'b1; a_data = 32'h08070605; c_data = '0;
        #1;
        chk("conflict_w_ready", 80'(if_s.w_ready), 80'(0));
        chk("conflict_a_ready", 80'(if_s.a_ready), 80'(1));
        @(negedge clk);
        a_valid = 1'b0;
        seen_y = -1; lat_w = -1; yc = '0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (if_s.y_valid && seen_y < 0) begin
                seen_y = n;
                yc = if_s.y_data;
            end
            if (if_s.w_ready) begin
                lat_w = n;
                break;
            end
            @(negedge clk);
        end
        chk("conflict_y_cycle", 80'(seen_y), 80'(9));
        chk("conflict_y_data", yc, 80'h00008_00007_00006_00005);
        chk("conflict_w_ready_cycle", 80'(lat_w), 80'(10));
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        chk("conflict_beat_taken", 80'(if_s.weights_loaded), 80'(0));

        // reset part-way through a load
        beat(32'h01000000);
        beat(32'h00010000);
        do_reset();
        chk("midload_loaded", 80'(if_s.weights_loaded), 80'(0));
        chk("midload_a_ready", 80'(if_s.a_ready), 80'(0));
        chk("midload_y_data", if_s.y_data, 80'(0));
        for (int b = 0; b < 3; b++) beat(tbl[0].beats[32*b +: 32]);
        chk("reload3_a_ready", 80'(if_s.a_ready), 80'(0));
        beat(tbl[0].beats[96 +: 32]);
        chk("reload4_a_ready", 80'(if_s.a_ready), 80'(1));
        run_vec(32'h06070809, '0, ys, yu, yw, lat);
        chk("reload_latency", 80'(lat), 80'(8));
        chk("reload_y", ys, 80'h00006_00007_00008_00009);

        // reset with three vectors in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_data  = 32'h01010101 * (k + 1);
        end
        @(negedge clk);
        a_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (if_s.y_valid || if_u.y_valid || if_w.y_valid) pulses++;
            @(negedge clk);
        end
        chk("flight_rst_pulses", 80'(pulses), 80'(0));
        chk("flight_rst_y_data", if_s.y_data, 80'(0));
        chk("flight_rst_loaded", 80'(if_s.weights_loaded), 80'(0));
        chk("flight_rst_a_ready", 80'(if_s.a_ready), 80'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
